// File: rtl/accum_sched_pkg.sv
// Shared types and default sizes for the accum_sched block.
// Optional saturation is selected by the ACCUM_SAT_EN macro in accum_datapath.
package accum_sched_pkg;

    localparam int DEF_WIDTH = 10;
    localparam int DEF_TW    = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/accum_datapath.sv
// Triangular-number generator: counter increments, buffer accumulates counter+buffer.
// Define ACCUM_SAT_EN to clamp the sum at 2^WIDTH-1 instead of wrapping.
module accum_datapath
    import accum_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH-1:0] counter;
    logic [WIDTH-1:0] buffer;

`ifdef ACCUM_SAT_EN
    logic [WIDTH:0] sum_wide;

    // Carry out of the wide add means the true sum no longer fits, so pin it at all-ones.
    assign sum_wide = {1'b0, counter} + {1'b0, buffer};
    assign sum      = sum_wide[WIDTH] ? {WIDTH{1'b1}} : sum_wide[WIDTH-1:0];
`else
    assign sum = counter + buffer;
`endif

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            counter <= '0;
            buffer  <= '0;
        end else if (en) begin
            counter <= counter + 1'b1;
            buffer  <= sum;
        end
    end

endmodule

// File: rtl/accum_sched.sv
// Run scheduler: steps the accumulator for t_end+1 ticks and captures the sum on two ports.
// Saturating accumulation is enabled by defining ACCUM_SAT_EN (see accum_datapath).
module accum_sched
    import accum_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int TW    = DEF_TW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [TW-1:0]    cap_a,
    input  logic [TW-1:0]    cap_b,
    input  logic [TW-1:0]    t_end,
    output logic             start_ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] port_a,
    output logic [WIDTH-1:0] port_b,
    output logic             valid_a,
    output logic             valid_b
);

    state_t           state;
    logic [TW-1:0]    tick;
    logic [TW-1:0]    cap_a_q;
    logic [TW-1:0]    cap_b_q;
    logic [TW-1:0]    t_end_q;
    logic [WIDTH-1:0] sum;
    logic             dp_clr;
    logic             dp_en;

    assign dp_clr = (state == IDLE) && start;
    assign dp_en  = (state == RUN);

    accum_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk   (clk),
        .reset (reset),
        .clr   (dp_clr),
        .en    (dp_en),
        .sum   (sum)
    );

    // Status outputs are registered alongside the state so they always match it exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            tick        <= '0;
            cap_a_q     <= '0;
            cap_b_q     <= '0;
            t_end_q     <= '0;
            port_a      <= '0;
            port_b      <= '0;
            valid_a     <= 1'b0;
            valid_b     <= 1'b0;
            start_ready <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= RUN;
                        cap_a_q     <= cap_a;
                        cap_b_q     <= cap_b;
                        t_end_q     <= t_end;
                        tick        <= '0;
                        valid_a     <= 1'b0;
                        valid_b     <= 1'b0;
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                RUN: begin
                    tick <= tick + 1'b1;
                    if (tick == cap_a_q) begin
                        port_a  <= sum;
                        valid_a <= 1'b1;
                    end
                    if (tick == cap_b_q) begin
                        port_b  <= sum;
                        valid_b <= 1'b1;
                    end
                    // Abort outranks the end-of-run transition, so no done pulse follows it.
                    if (abort) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        start_ready <= 1'b1;
                    end else if (tick == t_end_q) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    start_ready <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    start_ready <= 1'b1;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accum_sched.sv
// Self-checking bench for accum_sched: table of runs scored through a queue, plus abort/reset sequences.
// Expected sums follow the ACCUM_SAT_EN setting the bench is compiled with.
module tb_accum_sched;
    import accum_sched_pkg::*;

    localparam int WIDTH = DEF_WIDTH;
    localparam int TW    = DEF_TW;
    localparam int NVEC  = 7;

    typedef struct {
        int cap_a;
        int cap_b;
        int t_end;
        int exp_a;
        int exp_b;
        int exp_va;
        int exp_vb;
    } vec_t;

    logic             clk;
    logic             reset;
    logic             start;
    logic             abort;
    logic [TW-1:0]    cap_a;
    logic [TW-1:0]    cap_b;
    logic [TW-1:0]    t_end;
    logic             start_ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] port_a;
    logic [WIDTH-1:0] port_b;
    logic             valid_a;
    logic             valid_b;

    vec_t vecs [NVEC];
    vec_t sb_q [$];
    int   total   = 0;
    int   bad     = 0;
    int   model_a = 0;
    int   model_b = 0;

    accum_sched #(
        .WIDTH (WIDTH),
        .TW    (TW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .cap_a       (cap_a),
        .cap_b       (cap_b),
        .t_end       (t_end),
        .start_ready (start_ready),
        .busy        (busy),
        .done        (done),
        .port_a      (port_a),
        .port_b      (port_b),
        .valid_a     (valid_a),
        .valid_b     (valid_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Closed-form triangular number, reduced the way the accumulator should reduce it.
    function automatic int tri_sum(input int k);
        int s;
        s = k * (k + 1) / 2;
`ifdef ACCUM_SAT_EN
        if (s > (1 << WIDTH) - 1) s = (1 << WIDTH) - 1;
`else
        s = s % (1 << WIDTH);
`endif
        return s;
    endfunction

    task automatic check_output(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Builds a vector's expectations from the running port model, then advances the model.
    task automatic make_vec(input int ca, input int cb, input int te, output vec_t v);
        v.cap_a  = ca;
        v.cap_b  = cb;
        v.t_end  = te;
        v.exp_va = (ca <= te) ? 1 : 0;
        v.exp_vb = (cb <= te) ? 1 : 0;
        v.exp_a  = (ca <= te) ? tri_sum(ca) : model_a;
        v.exp_b  = (cb <= te) ? tri_sum(cb) : model_b;
        model_a  = v.exp_a;
        model_b  = v.exp_b;
    endtask

    task automatic start_run(input int ca, input int cb, input int te);
        @(negedge clk);
        cap_a = TW'(ca);
        cap_b = TW'(cb);
        t_end = TW'(te);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drives start and abort together to show start wins in IDLE, then scrambles config mid-run.
    task automatic apply_stimulus(input vec_t v);
        int   cycles;
        vec_t exp;
        @(negedge clk);
        cap_a = TW'(v.cap_a);
        cap_b = TW'(v.cap_b);
        t_end = TW'(v.t_end);
        start = 1'b1;
        abort = 1'b1;
        sb_q.push_back(v);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        cap_a = TW'($urandom);
        cap_b = TW'($urandom);
        t_end = TW'($urandom);
        check_output("busy_after_start", int'(busy), 1);
        cycles = 0;
        while (busy && cycles < 200) begin
            cycles++;
            @(negedge clk);
        end
        check_output("run_length", cycles, v.t_end + 1);
        check_output("done_pulse", int'(done), 1);
        @(negedge clk);
        check_output("done_cleared", int'(done), 0);
        check_output("ready_after_done", int'(start_ready), 1);
        if (sb_q.size() == 0) begin
            check_output("scoreboard_empty", 0, 1);
        end else begin
            exp = sb_q.pop_front();
            check_output("port_a", int'(port_a), exp.exp_a);
            check_output("port_b", int'(port_b), exp.exp_b);
            check_output("valid_a", int'(valid_a), exp.exp_va);
            check_output("valid_b", int'(valid_b), exp.exp_vb);
        end
    endtask

    initial begin
        vec_t v;
        bit   seen_done;

        make_vec(10, 20, 21, vecs[0]);
        make_vec(5, 5, 5, vecs[1]);
        make_vec(45, 50, 50, vecs[2]);
        make_vec(0, 63, 0, vecs[3]);
        make_vec(7, 3, 8, vecs[4]);
        make_vec(63, 63, 63, vecs[5]);
        make_vec(40, 2, 20, vecs[6]);

        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        cap_a = '0;
        cap_b = '0;
        t_end = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_output("reset_ready", int'(start_ready), 1);
        check_output("reset_busy", int'(busy), 0);
        check_output("reset_done", int'(done), 0);
        check_output("reset_port_a", int'(port_a), 0);
        check_output("reset_valid_b", int'(valid_b), 0);

        for (int i = 0; i < NVEC; i++) apply_stimulus(vecs[i]);

        // Abort at tick 35 after capturing A at 30; a start at tick 10 must be ignored.
        start_run(30, 40, 50);
        seen_done = 1'b0;
        for (int i = 0; i < 35; i++) begin
            if (i == 10) begin
                start = 1'b1;
                cap_a = TW'(1);
                t_end = TW'(2);
            end
            if (i == 11) start = 1'b0;
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check_output("abort_still_busy", int'(busy), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_output("abort_ready", int'(start_ready), 1);
        check_output("abort_busy", int'(busy), 0);
        check_output("abort_done", int'(done) | int'(seen_done), 0);
        check_output("abort_port_a", int'(port_a), tri_sum(30));
        check_output("abort_valid_a", int'(valid_a), 1);
        check_output("abort_valid_b", int'(valid_b), 0);
        check_output("abort_port_b_hold", int'(port_b), model_b);
        @(negedge clk);
        check_output("abort_no_late_done", int'(done), 0);
        model_a = tri_sum(30);

        // Abort landing on both the capture tick and t_end: capture happens, no done.
        start_run(4, 9, 4);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_output("abortcap_port_a", int'(port_a), tri_sum(4));
        check_output("abortcap_valid_a", int'(valid_a), 1);
        check_output("abortcap_done", int'(done), 0);
        check_output("abortcap_ready", int'(start_ready), 1);
        @(negedge clk);
        check_output("abortcap_no_done", int'(done), 0);
        model_a = tri_sum(4);

        // Reset during tick 12 must clear everything, including the datapath.
        start_run(30, 40, 50);
        repeat (12) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_output("midreset_ready", int'(start_ready), 1);
        check_output("midreset_busy", int'(busy), 0);
        check_output("midreset_port_a", int'(port_a), 0);
        check_output("midreset_port_b", int'(port_b), 0);
        check_output("midreset_valid_a", int'(valid_a), 0);
        model_a = 0;
        model_b = 0;
        make_vec(3, 63, 3, v);
        apply_stimulus(v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
